// File: rtl/vga_timing_pkg.sv
`timescale 1ns/1ps
// Shared VGA timing defaults (640x480 @ 60 Hz) and frame-geometry helpers.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 29;

    localparam int unsigned DEF_COLOR_W  = 4;
    localparam int unsigned DEF_PIPE_LAT = 1;
    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned MAX_PIPE_LAT = 7;

    // Timing signals that travel together through the latency-matching delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_H_TOTAL = h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = v_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_delay_line.sv
`timescale 1ns/1ps
// Enable-gated shift register of parameterised depth; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int unsigned      DEPTH   = 1,
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    if (DEPTH == 0) begin : g_wire
        assign delayed = data;
    end else begin : g_pipe
        localparam int unsigned PW = DEPTH * WIDTH;

        // Oldest sample sits in the most significant WIDTH bits.
        logic [PW-1:0] pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe <= {DEPTH{RST_VAL}};
            end else if (en) begin
                pipe <= PW'({pipe, data});
            end
        end

        assign delayed = pipe[PW-1 -: WIDTH];
    end

endmodule

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing generator: fetch coordinates, line/frame pulses, and
// latency-matched sync, display enable and blanked colour.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = DEF_COLOR_W,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic                 pix_en,
    input  logic [3*COLOR_W-1:0] vga_data,
    output logic [ADDR_W-1:0]    h_addr,
    output logic [ADDR_W-1:0]    v_addr,
    output logic                 addr_valid,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // One extra code point so the sync-end boundary always fits the counter width.
    localparam int unsigned XW = cnt_width(H_TOTAL + 1);
    localparam int unsigned YW = cnt_width(V_TOTAL + 1);

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0};

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_act;
    logic          y_act;
    logic          x_zero;
    sync_t         raw;
    sync_t         dly;
    logic          show;

    // Raster position; both coordinates wrap together on the last pixel of the frame.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (pix_en) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Zero-latency fetch coordinate, pulses and undelayed sync levels.
    always_comb begin
        x_act       = (x < X_ACT);
        y_act       = (y < Y_ACT);
        x_zero      = (x == '0);
        addr_valid  = x_act & y_act;
        h_addr      = addr_valid ? ADDR_W'(x) : '0;
        v_addr      = addr_valid ? ADDR_W'(y) : '0;
        line_start  = pix_en & x_zero & y_act;
        frame_start = pix_en & x_zero & (y == '0);
        raw.hsync   = ((x >= HS_BEG) && (x < HS_END)) ? HS_POL : ~HS_POL;
        raw.vsync   = ((y >= VS_BEG) && (y < VS_END)) ? VS_POL : ~VS_POL;
        raw.de      = addr_valid;
    end

    // Match sync and enable to the upstream pixel-fetch latency.
    vga_delay_line #(
        .DEPTH   (PIPE_LAT),
        .WIDTH   ($bits(sync_t)),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk     (pclk),
        .rst_n   (reset_n),
        .en      (pix_en),
        .data    (raw),
        .delayed (dly)
    );

    // Reset also blanks colour so a zero-latency pipe cannot leak data while held.
    always_comb begin
        hsync = dly.hsync;
        vsync = dly.vsync;
        de    = dly.de;
        show  = dly.de & reset_n;
        vga_r = show ? vga_data[3*COLOR_W-1 -: COLOR_W] : '0;
        vga_g = show ? vga_data[2*COLOR_W-1 -: COLOR_W] : '0;
        vga_b = show ? vga_data[COLOR_W-1   -: COLOR_W] : '0;
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Self-checking bench for vga_timing_gen: directed timing measurements on the
// default mode plus randomised runs of small modes against a raster-position model.
module tb_vga_timing_gen;

    localparam int S_HA = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VA = 5;
    localparam int S_VF = 1;
    localparam int S_VS = 2;
    localparam int S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;

    typedef struct {
        int   ha, hf, hsw, hb, va, vf, vsw, vb, lat;
        logic hp, vp;
    } cfg_t;

    typedef struct {
        logic        av;
        logic [31:0] hx, vy;
        logic        ls, fs, hs, vs, de;
        logic [3:0]  r, g, b;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-mode DUT
    logic        rst_a, pe_a;
    logic [11:0] data_a;
    logic [9:0]  ha_a, va_a;
    logic        av_a, ls_a, fs_a, hs_a, vs_a, de_a;
    logic [3:0]  r_a, g_a, b_a;

    // Small-mode DUTs sharing stimulus: B (latency 3, positive sync), Z (latency 0)
    logic        rst_s, pe_s;
    logic [11:0] data_s;
    logic [5:0]  ha_b, va_b, ha_z, va_z;
    logic        av_b, ls_b, fs_b, hs_b, vs_b, de_b;
    logic        av_z, ls_z, fs_z, hs_z, vs_z, de_z;
    logic [3:0]  r_b, g_b, b_b, r_z, g_z, b_z;

    vga_timing_gen u_dut_a (
        .pclk(clk), .reset_n(rst_a), .pix_en(pe_a), .vga_data(data_a),
        .h_addr(ha_a), .v_addr(va_a), .addr_valid(av_a),
        .line_start(ls_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .PIPE_LAT(3), .ADDR_W(6)
    ) u_dut_b (
        .pclk(clk), .reset_n(rst_s), .pix_en(pe_s), .vga_data(data_s),
        .h_addr(ha_b), .v_addr(va_b), .addr_valid(av_b),
        .line_start(ls_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .PIPE_LAT(0), .ADDR_W(6)
    ) u_dut_z (
        .pclk(clk), .reset_n(rst_s), .pix_en(pe_s), .vga_data(data_s),
        .h_addr(ha_z), .v_addr(va_z), .addr_valid(av_z),
        .line_start(ls_z), .frame_start(fs_z),
        .hsync(hs_z), .vsync(vs_z), .de(de_z),
        .vga_r(r_z), .vga_g(g_z), .vga_b(b_z)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint n_a, n_s;
    cfg_t   cfg_a, cfg_b, cfg_z;
    int     hs_fall, hs_rise, ls_first, ls_second, fs_cnt, fs_max;
    int     av_first, de_first, r_at_de, found;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after n enabled ticks since reset, from the raster rules.
    function automatic obs_t model(input cfg_t c, input longint n, input logic pe,
                                   input logic [11:0] data, input logic in_rst);
        obs_t   e;
        int     ht, vt, x, y, xd, yd;
        longint nd;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        x  = int'(n % ht);
        y  = int'((n / ht) % vt);
        e.av = (x < c.ha) && (y < c.va);
        e.hx = e.av ? 32'(x) : 32'd0;
        e.vy = e.av ? 32'(y) : 32'd0;
        e.fs = pe && (x == 0) && (y == 0);
        e.ls = pe && (x == 0) && (y < c.va);
        if (n >= longint'(c.lat)) begin
            nd   = n - c.lat;
            xd   = int'(nd % ht);
            yd   = int'((nd / ht) % vt);
            e.hs = (xd >= c.ha + c.hf && xd < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
            e.vs = (yd >= c.va + c.vf && yd < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
            e.de = (xd < c.ha) && (yd < c.va);
        end else begin
            e.hs = ~c.hp;
            e.vs = ~c.vp;
            e.de = 1'b0;
        end
        if (e.de && !in_rst) begin
            e.r = data[11:8];
            e.g = data[7:4];
            e.b = data[3:0];
        end else begin
            e.r = 4'h0;
            e.g = 4'h0;
            e.b = 4'h0;
        end
        return e;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.av = av_a; o.hx = 32'(ha_a); o.vy = 32'(va_a);
        o.ls = ls_a; o.fs = fs_a; o.hs = hs_a; o.vs = vs_a; o.de = de_a;
        o.r = r_a; o.g = g_a; o.b = b_a;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.av = av_b; o.hx = 32'(ha_b); o.vy = 32'(va_b);
        o.ls = ls_b; o.fs = fs_b; o.hs = hs_b; o.vs = vs_b; o.de = de_b;
        o.r = r_b; o.g = g_b; o.b = b_b;
        return o;
    endfunction

    function automatic obs_t obs_z();
        obs_t o;
        o.av = av_z; o.hx = 32'(ha_z); o.vy = 32'(va_z);
        o.ls = ls_z; o.fs = fs_z; o.hs = hs_z; o.vs = vs_z; o.de = de_z;
        o.r = r_z; o.g = g_z; o.b = b_z;
        return o;
    endfunction

    task automatic cmp_obs(input string who, input obs_t g, input obs_t e);
        check_eq({who, ".addr_valid"},  32'(g.av), 32'(e.av));
        check_eq({who, ".h_addr"},      g.hx,      e.hx);
        check_eq({who, ".v_addr"},      g.vy,      e.vy);
        check_eq({who, ".line_start"},  32'(g.ls), 32'(e.ls));
        check_eq({who, ".frame_start"}, 32'(g.fs), 32'(e.fs));
        check_eq({who, ".hsync"},       32'(g.hs), 32'(e.hs));
        check_eq({who, ".vsync"},       32'(g.vs), 32'(e.vs));
        check_eq({who, ".de"},          32'(g.de), 32'(e.de));
        check_eq({who, ".vga_r"},       32'(g.r),  32'(e.r));
        check_eq({who, ".vga_g"},       32'(g.g),  32'(e.g));
        check_eq({who, ".vga_b"},       32'(g.b),  32'(e.b));
    endtask

    // One default-mode run starting at a negedge; records sync/pulse timing.
    task automatic run_a(input int cycles, input bit toggle, input bit rand_data);
        logic prev_hs;
        int   run;
        hs_fall = -1; hs_rise = -1; ls_first = -1; ls_second = -1;
        fs_cnt = 0; fs_max = 0; run = 0; prev_hs = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            pe_a = toggle ? (c % 2 == 0) : 1'b1;
            if (rand_data) data_a = 12'($urandom);
            #1;
            cmp_obs("a", obs_a(), model(cfg_a, n_a, pe_a, data_a, !rst_a));
            if (prev_hs && !hs_a && hs_fall < 0) hs_fall = c;
            if (!prev_hs && hs_a && hs_fall >= 0 && hs_rise < 0) hs_rise = c;
            prev_hs = hs_a;
            if (ls_a) begin
                if (ls_first < 0) ls_first = c;
                else if (ls_second < 0) ls_second = c;
            end
            if (fs_a) begin
                fs_cnt++;
                run++;
                if (run > fs_max) fs_max = run;
            end else begin
                run = 0;
            end
            @(posedge clk);
            if (rst_a && pe_a) n_a++;
            @(negedge clk);
        end
    endtask

    task automatic drive_check_s(input logic pe, input logic [11:0] d);
        pe_s   = pe;
        data_s = d;
        #1;
        cmp_obs("b", obs_b(), model(cfg_b, n_s, pe_s, data_s, !rst_s));
        cmp_obs("z", obs_z(), model(cfg_z, n_s, pe_s, data_s, !rst_s));
    endtask

    task automatic advance_s();
        @(posedge clk);
        if (rst_s && pe_s) n_s++;
        @(negedge clk);
    endtask

    task automatic random_s(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive_check_s(logic'($urandom_range(3, 0) != 0), 12'($urandom));
            advance_s();
        end
    endtask

    initial begin
        cfg_a = '{ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 29,
                  lat: 1, hp: 1'b0, vp: 1'b0};
        cfg_b = '{ha: S_HA, hf: S_HF, hsw: S_HS, hb: S_HB, va: S_VA, vf: S_VF, vsw: S_VS,
                  vb: S_VB, lat: 3, hp: 1'b1, vp: 1'b1};
        cfg_z = '{ha: S_HA, hf: S_HF, hsw: S_HS, hb: S_HB, va: S_VA, vf: S_VF, vsw: S_VS,
                  vb: S_VB, lat: 0, hp: 1'b0, vp: 1'b0};
        rst_a = 1'b0; pe_a = 1'b1; data_a = 12'hFFF;
        rst_s = 1'b0; pe_s = 1'b1; data_s = 12'hFFF;
        n_a = 0; n_s = 0;

        // Reset state, including positive-polarity idle levels while held
        repeat (2) @(negedge clk);
        #1;
        cmp_obs("a_rst", obs_a(), model(cfg_a, 0, pe_a, data_a, 1'b1));
        cmp_obs("b_rst", obs_b(), model(cfg_b, 0, pe_s, data_s, 1'b1));
        cmp_obs("z_rst", obs_z(), model(cfg_z, 0, pe_s, data_s, 1'b1));
        check_eq("b_rst_hsync_idle", 32'(hs_b), 32'd0);
        check_eq("b_rst_vsync_idle", 32'(vs_b), 32'd0);
        @(negedge clk);

        // Default mode, continuous enable, constant white data
        rst_a = 1'b1; n_a = 0;
        run_a(1700, 1'b0, 1'b0);
        check_eq("a_hs_fall",     32'(hs_fall), 32'd657);
        check_eq("a_hs_width",    32'(hs_rise - hs_fall), 32'd96);
        check_eq("a_first_line",  32'(ls_first), 32'd0);
        check_eq("a_line_period", 32'(ls_second - ls_first), 32'd800);
        check_eq("a_fs_count",    32'(fs_cnt), 32'd1);
        check_eq("a_fs_width",    32'(fs_max), 32'd1);

        // Re-reset, then enable toggling every pclk with random data
        rst_a = 1'b0; n_a = 0;
        #1;
        cmp_obs("a_rst2", obs_a(), model(cfg_a, 0, pe_a, data_a, 1'b1));
        @(negedge clk);
        rst_a = 1'b1;
        run_a(3400, 1'b1, 1'b1);
        check_eq("a_tog_hs_fall",     32'(hs_fall), 32'd1313);
        check_eq("a_tog_hs_width",    32'(hs_rise - hs_fall), 32'd192);
        check_eq("a_tog_line_period", 32'(ls_second - ls_first), 32'd1600);
        check_eq("a_tog_fs_width",    32'(fs_max), 32'd1);

        // Small modes: latency-3 alignment with red at (0,0)
        rst_s = 1'b1; n_s = 0;
        av_first = -1; de_first = -1; r_at_de = -1;
        for (int c = 0; c < 12; c++) begin
            drive_check_s(1'b1, 12'hF00);
            if (av_b && av_first < 0) av_first = c;
            if (de_b && de_first < 0) begin
                de_first = c;
                r_at_de  = 32'(r_b);
            end
            advance_s();
        end
        check_eq("b_av_first", 32'(av_first), 32'd0);
        check_eq("b_de_lag",   32'(de_first - av_first), 32'd3);
        check_eq("b_r_at_de",  32'(r_at_de), 32'hF);

        random_s(1500);

        // Walk to row 3, column 5 and reset asynchronously mid-cycle
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            if (n_s % S_FT == longint'(3 * S_HT + 5)) found = 1;
            else begin
                drive_check_s(logic'($urandom_range(3, 0) != 0), 12'($urandom));
                advance_s();
            end
        end
        check_eq("s_reach_pos", 32'(found), 32'd1);
        pe_s = 1'b1;
        data_s = 12'hFFF;
        #2;
        rst_s = 1'b0; n_s = 0;
        #1;
        cmp_obs("b_midrst", obs_b(), model(cfg_b, 0, pe_s, data_s, 1'b1));
        cmp_obs("z_midrst", obs_z(), model(cfg_z, 0, pe_s, data_s, 1'b1));
        @(negedge clk);
        random_s(3);
        rst_s = 1'b1;
        drive_check_s(1'b1, 12'($urandom));
        check_eq("b_fs_after_rst", 32'(fs_b), 32'd1);
        check_eq("z_fs_after_rst", 32'(fs_z), 32'd1);
        advance_s();

        random_s(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch, sync and back porch widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/29, vertical front porch, sync and back porch widths in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, asserted sync level (0 = active-low).
REQ-006 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-007 SHALL have parameter PIPE_LAT, default 1, range 0..7, upstream pixel-fetch latency in pix_en ticks.
REQ-008 SHALL have parameter ADDR_W, default 10, coordinate width.
REQ-009 SHALL have port pclk, input, 1, pixel clock, the single clock of the block.
REQ-010 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pix_en, input, 1, pixel tick enable; all state advances only when high.
REQ-012 SHALL have port vga_data, input, 3*COLOR_W, upstream colour as {r,g,b}, PIPE_LAT ticks after its address.
REQ-013 SHALL have ports h_addr and v_addr, output, ADDR_W each, current fetch coordinate, 0 outside active area.
REQ-014 SHALL have port addr_valid, output, 1, high when the fetch coordinate lies in the active area.
REQ-015 SHALL have ports line_start and frame_start, output, 1 each, single-pclk pulses.
REQ-016 SHALL have ports hsync, vsync and de, output, 1 each, latency-aligned sync and display enable.
REQ-017 SHALL have ports vga_r, vga_g and vga_b, output, COLOR_W each, colour to the DAC.

Function
REQ-018 SHALL keep counters x in 0..H_TOTAL-1 and y in 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-019 SHALL order each line and frame as active, front porch, sync, back porch, starting at count 0.
REQ-020 SHALL, on a pclk edge with pix_en=1: increment x; at x==H_TOTAL-1 wrap x to 0 and increment y; at y==V_TOTAL-1 wrap y to 0 as well.
REQ-021 SHALL hold all counters, delay stages and outputs when pix_en=0.
REQ-022 SHALL drive addr_valid = (x<H_ACTIVE)&(y<V_ACTIVE), h_addr = x and v_addr = y when valid, else 0, combinationally from the counters with zero latency.
REQ-023 SHALL form raw hsync = HS_POL while x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL; vsync is formed likewise from y, V_* and VS_POL.
REQ-024 SHALL delay raw hsync, vsync and addr_valid by exactly PIPE_LAT pix_en ticks to produce hsync, vsync and de; with PIPE_LAT=0 they are combinational pass-through.
REQ-025 SHALL drive vga_r/g/b from vga_data fields when de=1, and force them to 0 when de=0.
REQ-026 SHALL pulse frame_start for one pclk when x==0 & y==0 & pix_en.
REQ-027 SHALL pulse line_start for one pclk when x==0 & y<V_ACTIVE & pix_en.
REQ-028 SHALL let coordinate wrap (x and y both wrapping) take effect in the same tick as the frame_start of the next frame, with no extra idle tick.

Reset
REQ-029 SHALL, on reset_n low and asynchronously, clear x and y to 0, load delay stages with hsync=~HS_POL, vsync=~VS_POL and de=0, and force colour to 0.
REQ-030 SHALL, on reset mid-frame, abandon the frame; the first pix_en tick after release produces frame_start.

Structure
REQ-031 SHALL place default 640x480 timing constants and the H_TOTAL/V_TOTAL computations in shared package vga_timing_pkg.
REQ-032 SHALL implement the enable-gated, parametrised-depth shift register as sub-module vga_delay_line (parameters DEPTH, WIDTH).

Verification
REQ-033 SHALL verify defaults with pix_en=1: hsync low for 96 pclk starting 657 pclk after frame_start; line period 800; vsync low at lines 490-491; frame period 416800 pclk.
REQ-034 SHALL verify PIPE_LAT=3 with vga_data driven as 12'hF00 at address (0,0): vga_r=4'hF appears with de rising exactly 3 ticks after addr_valid rises.
REQ-035 SHALL verify pix_en toggling 1/0 every pclk: all periods double (line = 1600 pclk) and frame_start stays 1 pclk wide.
REQ-036 SHALL verify HS_POL=1, VS_POL=1: sync idles low and pulses high; idle levels hold immediately during reset.
REQ-037 SHALL verify reset_n asserted at y=200, x=300: outputs reach reset values without a pclk edge; after release, frame_start occurs on the first enabled tick.
REQ-038 SHALL verify colour stays 0 across blanking regardless of vga_data (drive 12'hFFF constantly).
